// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register: command encodings and FSM states.
package shift_pkg;

   typedef enum logic [2:0] {
      OP_HOLD = 3'd0,
      OP_LOAD = 3'd1,
      OP_SHL  = 3'd2,
      OP_SHR  = 3'd3,
      OP_ROL  = 3'd4,
      OP_ROR  = 3'd5,
      OP_ASR  = 3'd6,
      OP_RSVD = 3'd7
   } op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Ops that honour op_count and may run as a multi-cycle burst.
   function automatic logic is_step_op(input op_e op);
      return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) ||
             (op == OP_ROR) || (op == OP_ASR);
   endfunction

endpackage

// File: rtl/usr_step_logic.sv
// Combinational single-step next-value function for the shift register.
module usr_step_logic
   import shift_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q_i,
   input  op_e              op_i,
   input  logic [WIDTH-1:0] par_in_i,
   input  logic             ser_in_msb_i,
   input  logic             ser_in_lsb_i,
   output logic [WIDTH-1:0] q_d_o
);

   always_comb begin
      q_d_o = q_i;
      case (op_i)
         OP_LOAD: q_d_o = par_in_i;
         OP_SHL:  q_d_o = {q_i[WIDTH-2:0], ser_in_lsb_i};
         OP_SHR:  q_d_o = {ser_in_msb_i, q_i[WIDTH-1:1]};
         OP_ROL:  q_d_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
         OP_ROR:  q_d_o = {q_i[0], q_i[WIDTH-1:1]};
         OP_ASR:  q_d_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
         default: q_d_o = q_i;
      endcase
   end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register with a burst engine: one accepted command runs N single-bit steps.
module universal_shift_register
   import shift_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [2:0]       op,
   input  logic [CNT_W-1:0] op_count,
   input  logic [WIDTH-1:0] par_in,
   input  logic             ser_in_msb,
   input  logic             ser_in_lsb,
   output logic [WIDTH-1:0] q,
   output logic             ser_out_msb,
   output logic             ser_out_lsb,
   output logic             busy,
   output logic             done
);

   state_e           state_q;
   op_e              op_q;
   logic [CNT_W-1:0] rem_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic             done_q;
   op_e              op_in;
   op_e              step_op;

   assign op_in   = op_e'(op);
   // While bursting, the latched op drives the step; live op/op_count are ignored.
   assign step_op = (state_q == ST_RUN) ? op_q : op_in;

   usr_step_logic #(.WIDTH(WIDTH)) u_step (
      .q_i          (q_q),
      .op_i         (step_op),
      .par_in_i     (par_in),
      .ser_in_msb_i (ser_in_msb),
      .ser_in_lsb_i (ser_in_lsb),
      .q_d_o        (q_d)
   );

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= ST_IDLE;
         op_q    <= OP_HOLD;
         rem_q   <= '0;
         q_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (op_valid) begin
                  if (!is_step_op(op_in)) begin
                     q_q    <= q_d;
                     done_q <= 1'b1;
                  end else if (op_count == '0) begin
                     done_q <= 1'b1;
                  end else if (op_count == CNT_W'(1)) begin
                     q_q    <= q_d;
                     done_q <= 1'b1;
                  end else begin
                     q_q     <= q_d;
                     op_q    <= op_in;
                     rem_q   <= op_count - CNT_W'(1);
                     state_q <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               q_q <= q_d;
               if (rem_q == CNT_W'(1)) begin
                  rem_q   <= '0;
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end else begin
                  rem_q <= rem_q - CNT_W'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy        = (state_q == ST_RUN);
   assign op_ready    = !busy;
   assign q           = q_q;
   assign ser_out_msb = q_q[WIDTH-1];
   assign ser_out_lsb = q_q[0];
   assign done        = done_q;

endmodule
